fmsynth_cmd_player: RTL and testbench
=====================================

// Module: fmsynth_cmd_player
// PURPOSE
//  Bus initiator that drives the FM synth register port from a queue of timed commands.
//  The CPU pushes register writes and "wait N samples" commands into a FIFO.
//  The player replays them at sample-accurate times, honouring the synth's bus_wait stall.
//  Sits between the CPU-side command register and fmsynth bus_addr/bus_wrdata/bus_wren/bus_wait.
// PARAMETERS
//  DEPTH_LOG2  4    FIFO depth = 2**DEPTH_LOG2 commands
//  TICK_DIV    506  clocks per sample tick; must equal the synth's sample period
// PORTS
//  clk         in   1    single clock
//  reset       in   1    asynchronous, active-high
//  enable      in   1    1 = pop and execute commands; 0 = finish current command, then hold
//  flush       in   1    1-cycle pulse: empty the FIFO, abort any WAIT
//  cmd_valid   in   1    command push request
//  cmd_data    in   41   [40]=type (0 write, 1 wait); [39:32]=addr; [31:0]=data (wait: N=[15:0])
//  cmd_ready   out  1    = !full; push accepted on edge where cmd_valid && cmd_ready
//  fifo_level  out  DEPTH_LOG2+1  entries queued
//  busy        out  1    state != ST_IDLE || fifo_level != 0
//  bus_addr    out  8    synth register address
//  bus_wrdata  out  32   synth write data
//  bus_wren    out  1    write request; held until accepted
//  bus_wait    in   1    synth stall; transfer completes on a cycle with bus_wren && !bus_wait
//  stall_cnt   out  16   stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: bus_wren=0, bus_addr=0, bus_wrdata=0, FIFO empty, fifo_level=0, state ST_IDLE.
//  Reset: tick counter=0, wait counter=0, stall_cnt=0; cmd_ready=1, busy=0.
//  Tick: free-running counter 0..TICK_DIV-1; tick=1 in the cycle the counter equals TICK_DIV-1.
//  FIFO: registered, first-word-fall-through; push and pop allowed in the same cycle.
//  FIFO: push when full is ignored (cmd_ready=0). The pointer wraps modulo depth.
//  ST_IDLE:
//  - If enable && !empty: pop the head entry.
//  - type 0: register addr/data, set bus_wren=1, go to ST_WRITE.
//  - type 1, N!=0: load the wait counter with N, go to ST_WAIT.
//  - type 1, N=0: no-op; stay in ST_IDLE.
//  ST_WRITE:
//  - bus_addr/bus_wrdata/bus_wren are stable while bus_wait=1.
//  - On the first cycle with !bus_wait: clear bus_wren at that edge, go to ST_IDLE.
//  ST_WAIT: decrement the wait counter on each tick; when it reaches 0, go to ST_IDLE.
//  - A tick in the cycle the counter is loaded is not counted.
//  Latency: command accepted at edge E with FIFO empty and state ST_IDLE -> bus_wren high after edge E+1.
//  Peak throughput: 1 write per 2 clocks (ST_WRITE, ST_IDLE alternate).
//  bus_addr/bus_wrdata keep their last value after a transfer; only bus_wren drops.
//  flush: FIFO cleared at that edge. A push in the same cycle is discarded.
//  - flush in ST_WAIT: go to ST_IDLE, wait counter cleared.
//  - flush in ST_WRITE: the in-flight write completes normally; bus_wren is never dropped early.
//  enable=0: no pop. An in-progress WRITE or WAIT runs to completion.
//  Reset asserted mid-operation: all outputs return to reset values immediately (async).
//  Commands execute strictly in push order; no reordering or merging.
// CONFIGURATION
//  FMCP_STALL_CNT_EN defined:
//  - stall_cnt increments by 1 each cycle with bus_wren && bus_wait, saturating at 16'hFFFF.
//  - stall_cnt is cleared by reset and by flush.
//  FMCP_STALL_CNT_EN undefined: stall_cnt tied to 16'h0000; no counter logic.
// TESTING
//  T1: push {0,8'h02,32'h0000_0001}, bus_wait=0 -> bus_wren high exactly 1 cycle, addr=02, data=1.
//  T2: push a write with bus_wait=1 for 10 cycles -> bus_wren/addr/data stable for 11 cycles.
//  - T2 with FMCP_STALL_CNT_EN: stall_cnt=10.
//  T3: push wait N=3, then write 8'h80 -> write issued after exactly 3 ticks.
//  - Interval from ST_WAIT entry to bus_wren is 2*TICK_DIV+1 .. 3*TICK_DIV+1 cycles.
//  T4: enable=0, push 17 writes -> cmd_ready low after the 16th, fifo_level=16, 17th dropped.
//  - Then enable=1 -> 16 writes in push order, 2 cycles apart.
//  T5: in ST_WAIT with 5 queued, pulse flush -> ST_IDLE next cycle, fifo_level=0, busy=0, no writes.
//  T6: assert reset mid-ST_WRITE with bus_wait=1 -> bus_wren=0 at once; after release fifo_level=0.

Source files
------------

// File: rtl/fmsynth_cmd_player.sv
`default_nettype none
// ============================================================================
// Module      : fmsynth_cmd_player
// Description : Replays queued register writes and sample-tick waits onto the
//               FM synth register bus. Optional stall counter: FMCP_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fmsynth_cmd_player #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TICK_DIV   = 506
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  cmd_valid,
    input  logic [40:0]           cmd_data,
    output logic                  cmd_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  busy,
    output logic [7:0]            bus_addr,
    output logic [31:0]           bus_wrdata,
    output logic                  bus_wren,
    input  logic                  bus_wait,
    output logic [15:0]           stall_cnt
);

    localparam int c_depth  = 1 << DEPTH_LOG2;
    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic                  w_tick;
    logic [40:0]           r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [40:0]           w_head;
    logic                  w_load_write;
    logic                  w_load_wait;
    logic                  w_write_done;
    logic [15:0]           r_wait_cnt;
    logic [7:0]            r_bus_addr;
    logic [31:0]           r_bus_wrdata;
    logic                  r_bus_wren;

    assign w_tick = (r_tick_cnt == c_tick_w'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
        end
    end

    assign w_full  = (r_level == (DEPTH_LOG2 + 1)'(c_depth));
    assign w_empty = (r_level == '0);
    // A push coinciding with flush is discarded along with the queue.
    assign w_push  = cmd_valid && !w_full && !flush;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_load_write = 1'b0;
        w_load_wait  = 1'b0;
        w_write_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !w_empty && !flush) begin
                    w_pop = 1'b1;
                    if (!w_head[40]) begin
                        w_load_write = 1'b1;
                        w_state_nxt  = ST_WRITE;
                    end else if (w_head[15:0] != 16'd0) begin
                        w_load_wait = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                if (!bus_wait) begin
                    w_write_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush || (w_tick && r_wait_cnt == 16'd1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (flush) begin
            r_wait_cnt <= '0;
        end else if (w_load_wait) begin
            r_wait_cnt <= w_head[15:0];
        end else if (r_state == ST_WAIT && w_tick) begin
            r_wait_cnt <= r_wait_cnt - 16'd1;
        end
    end

    // Address and data persist after a transfer; only the request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_addr   <= '0;
            r_bus_wrdata <= '0;
            r_bus_wren   <= 1'b0;
        end else if (w_load_write) begin
            r_bus_addr   <= w_head[39:32];
            r_bus_wrdata <= w_head[31:0];
            r_bus_wren   <= 1'b1;
        end else if (w_write_done) begin
            r_bus_wren   <= 1'b0;
        end
    end

`ifdef FMCP_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (r_bus_wren && bus_wait && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign cmd_ready  = !w_full;
    assign fifo_level = r_level;
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign bus_addr   = r_bus_addr;
    assign bus_wrdata = r_bus_wrdata;
    assign bus_wren   = r_bus_wren;

endmodule
`default_nettype wire

// File: tb/tb_fmsynth_cmd_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmsynth_cmd_player
// Description : Directed self-checking bench for fmsynth_cmd_player.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmsynth_cmd_player;

    localparam int c_tick_div = 8;
`ifdef FMCP_STALL_CNT_EN
    localparam logic [15:0] c_exp_stall = 16'd10;
`else
    localparam logic [15:0] c_exp_stall = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        cmd_valid;
    logic [40:0] cmd_data;
    logic        cmd_ready;
    logic [4:0]  fifo_level;
    logic        busy;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wrdata;
    logic        bus_wren;
    logic        bus_wait;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    fmsynth_cmd_player #(.DEPTH_LOG2(4), .TICK_DIV(c_tick_div)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_wait   (bus_wait),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) step();
        checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", bus_wren); end
        checks++; if (bus_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus_addr); end
        checks++; if (bus_wrdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus_wrdata); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write;
        enable = 1'b1; bus_wait = 1'b0;
        cmd_valid = 1'b1; cmd_data = {1'b0, 8'h02, 32'h0000_0001};
        step();
        cmd_valid = 1'b0;
        checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL t1_early got %b exp 0", bus_wren); end
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL t1_level got %0d exp 1", fifo_level); end
        step();
        checks++; if (bus_wren !== 1'b1) begin errors++; $display("FAIL t1_wren got %b exp 1", bus_wren); end
        checks++; if (bus_addr !== 8'h02) begin errors++; $display("FAIL t1_addr got %h exp 02", bus_addr); end
        checks++; if (bus_wrdata !== 32'h1) begin errors++; $display("FAIL t1_data got %h exp 1", bus_wrdata); end
        step();
        checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL t1_drop got %b exp 0", bus_wren); end
        checks++; if (bus_addr !== 8'h02) begin errors++; $display("FAIL t1_hold_addr got %h exp 02", bus_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %b exp 0", busy); end
    endtask

    task automatic test_stall;
        bus_wait = 1'b1;
        cmd_valid = 1'b1; cmd_data = {1'b0, 8'h33, 32'hDEAD_BEEF};
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus_wren !== 1'b1 || bus_addr !== 8'h33 || bus_wrdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL t2_stable[%0d] got wren=%b addr=%h data=%h exp 1/33/deadbeef", i, bus_wren, bus_addr, bus_wrdata);
            end
            step();
        end
        bus_wait = 1'b0;
        checks++; if (bus_wren !== 1'b1) begin errors++; $display("FAIL t2_last got %b exp 1", bus_wren); end
        step();
        checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL t2_drop got %b exp 0", bus_wren); end
        checks++; if (stall_cnt !== c_exp_stall) begin errors++; $display("FAIL t2_stall got %0d exp %0d", stall_cnt, c_exp_stall); end
    endtask

    task automatic test_wait;
        int  cycles;
        bit  found;
        cmd_valid = 1'b1; cmd_data = {1'b1, 8'h00, 32'd3};
        step();
        cmd_data = {1'b0, 8'h80, 32'h1234_5678};
        step();
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_busy got %b exp 1", busy); end
        cycles = 0; found = 1'b0;
        for (int k = 0; k < 6 * c_tick_div && !found; k++) begin
            step();
            cycles++;
            if (bus_wren) found = 1'b1;
        end
        checks++;
        if (!found || cycles < 2 * c_tick_div + 1 || cycles > 3 * c_tick_div + 1) begin
            errors++;
            $display("FAIL t3_interval got %0d (found=%b) exp %0d..%0d", cycles, found, 2 * c_tick_div + 1, 3 * c_tick_div + 1);
        end
        checks++; if (bus_addr !== 8'h80) begin errors++; $display("FAIL t3_addr got %h exp 80", bus_addr); end
        step();
        // wait N=0 is a no-op: the following write issues one pop later
        cmd_valid = 1'b1; cmd_data = {1'b1, 8'h00, 32'd0};
        step();
        cmd_data = {1'b0, 8'h44, 32'h44};
        step();
        cmd_valid = 1'b0;
        checks++; if (bus_wren !== 1'b0 || fifo_level !== 5'd1) begin errors++; $display("FAIL t3_nop got wren=%b level=%0d exp 0/1", bus_wren, fifo_level); end
        step();
        checks++; if (bus_wren !== 1'b1 || bus_addr !== 8'h44) begin errors++; $display("FAIL t3_after_nop got wren=%b addr=%h exp 1/44", bus_wren, bus_addr); end
        step();
    endtask

    task automatic test_full_fifo;
        logic [7:0]  a;
        logic [31:0] d;
        int          stray;
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (cmd_ready !== (i < 16)) begin errors++; $display("FAIL t4_ready[%0d] got %b exp %b", i, cmd_ready, (i < 16)); end
            a = 8'h10 + 8'(i);
            d = 32'hA000_0000 + 32'(i);
            cmd_valid = 1'b1; cmd_data = {1'b0, a, d};
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL t4_level got %0d exp 16", fifo_level); end
        checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL t4_hold got %b exp 0", bus_wren); end
        enable = 1'b1;
        for (int j = 0; j < 16; j++) begin
            a = 8'h10 + 8'(j);
            d = 32'hA000_0000 + 32'(j);
            step();
            checks++;
            if (bus_wren !== 1'b1 || bus_addr !== a || bus_wrdata !== d) begin
                errors++;
                $display("FAIL t4_order[%0d] got wren=%b addr=%h data=%h exp 1/%h/%h", j, bus_wren, bus_addr, bus_wrdata, a, d);
            end
            step();
            checks++; if (bus_wren !== 1'b0) begin errors++; $display("FAIL t4_gap[%0d] got %b exp 0", j, bus_wren); end
        end
        stray = 0;
        repeat (4) begin step(); if (bus_wren) stray++; end
        checks++; if (stray !== 0 || busy !== 1'b0) begin errors++; $display("FAIL t4_extra got writes=%0d busy=%b exp 0/0", stray, busy); end
    endtask

    task automatic test_flush;
        int writes;
        enable = 1'b1; bus_wait = 1'b0;
        cmd_valid = 1'b1; cmd_data = {1'b1, 8'h00, 32'd100};
        step();
        for (int i = 0; i < 5; i++) begin
            cmd_data = {1'b0, 8'hC0 + 8'(i), 32'(i)};
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (fifo_level !== 5'd5 || busy !== 1'b1) begin errors++; $display("FAIL t5_pre got level=%0d busy=%b exp 5/1", fifo_level, busy); end
        checks++; if (stall_cnt !== c_exp_stall) begin errors++; $display("FAIL t5_stall_pre got %0d exp %0d", stall_cnt, c_exp_stall); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t5_level got %0d exp 0", fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", busy); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL t5_stall got %0d exp 0", stall_cnt); end
        writes = 0;
        repeat (20) begin step(); if (bus_wren) writes++; end
        checks++; if (writes !== 0) begin errors++; $display("FAIL t5_writes got %0d exp 0", writes); end
    endtask

    task automatic test_reset_mid_write;
        bus_wait = 1'b1;
        cmd_valid = 1'b1; cmd_data = {1'b0, 8'h55, 32'h5555_AAAA};
        step();
        cmd_data = {1'b0, 8'h66, 32'h6666_0000};
        step();
        cmd_valid = 1'b0;
        checks++; if (bus_wren !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL t6_pre got wren=%b level=%0d exp 1/1", bus_wren, fifo_level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_wren !== 1'b0 || bus_addr !== 8'h00 || bus_wrdata !== 32'h0) begin
            errors++; $display("FAIL t6_async got wren=%b addr=%h data=%h exp 0/00/0", bus_wren, bus_addr, bus_wrdata);
        end
        checks++; if (fifo_level !== 5'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL t6_fifo got level=%0d busy=%b ready=%b exp 0/0/1", fifo_level, busy, cmd_ready);
        end
        step();
        reset = 1'b0; bus_wait = 1'b0;
        step();
        step();
        checks++; if (fifo_level !== 5'd0 || bus_wren !== 1'b0) begin errors++; $display("FAIL t6_post got level=%0d wren=%b exp 0/0", fifo_level, bus_wren); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        cmd_valid = 1'b0; cmd_data = '0; bus_wait = 1'b0;
        test_reset();
        test_single_write();
        test_stall();
        test_wait();
        test_full_fifo();
        test_flush();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got no completion exp finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
